// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, pointer-advance helper and flag struct for sync_fifo_param
package fifo_pkg;
  typedef int unsigned ptr_idx_t;
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  // Explicit wrap so non-power-of-two depths never index past DEPTH-1
  function automatic ptr_idx_t ptr_adv(input ptr_idx_t p, input ptr_idx_t depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH register array, one write port, one registered read port
//   clk/reset : clock, sync active-high reset (clears rdata only, not the array)
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata updates on re and holds otherwise
module fifo_mem import fifo_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    rdata <= reset ? '0 : re ? mem[raddr] : rdata;
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with count, threshold flags and sticky errors
//   inputs : clk, reset (sync, active-high), write/data_in, read, clear_err
//   outputs: data_out/rd_valid (registered read), empty, full, almost_empty,
//            almost_full, count, overflow, underflow (sticky)
//   define SYNC_FIFO_PARAM_ASSERTIONS_EN to compile the embedded protocol assertions
module sync_fifo_param import fifo_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      write,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      read,
  input  logic                      clear_err,
  output logic [WIDTH-1:0]          data_out,
  output logic                      rd_valid,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic valid_read, valid_write;
  fifo_flags_t flags;
  assign valid_read  = read && !flags.empty;
  assign valid_write = write && (!flags.full || read);
  always_comb begin
    flags.empty        = count == '0;
    flags.full         = count == CW'(DEPTH);
    flags.almost_empty = count <= CW'(AE_LEVEL);
    flags.almost_full  = count >= CW'(AF_LEVEL);
  end
  assign empty        = flags.empty;
  assign full         = flags.full;
  assign almost_empty = flags.almost_empty;
  assign almost_full  = flags.almost_full;
  // Reset outranks requests, so nothing reaches the array on a reset edge
  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (valid_write && !reset),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (valid_read && !reset),
    .raddr (rd_ptr),
    .rdata (data_out)
  );
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (valid_write) wr_ptr <= PW'(ptr_adv(ptr_idx_t'(wr_ptr), DEPTH));
      if (valid_read) rd_ptr <= PW'(ptr_adv(ptr_idx_t'(rd_ptr), DEPTH));
      count     <= (valid_write && !valid_read) ? count + CW'(1) :
                   (valid_read && !valid_write) ? count - CW'(1) : count;
      rd_valid  <= valid_read;
      // Set wins over clear_err in the same cycle
      overflow  <= (write && !valid_write) || (overflow && !clear_err);
      underflow <= (read && !valid_read) || (underflow && !clear_err);
    end
`ifdef SYNC_FIFO_PARAM_ASSERTIONS_EN
  a_go_empty: assert property (@(posedge clk) disable iff (reset)
    (count == CW'(1) && valid_read && !valid_write) |=> empty);
  a_go_full: assert property (@(posedge clk) disable iff (reset)
    (count == CW'(DEPTH - 1) && valid_write && !valid_read) |=> full);
  a_not_empty: assert property (@(posedge clk) disable iff (reset)
    (count > '0) |-> !empty);
  a_not_full: assert property (@(posedge clk) disable iff (reset)
    (count < CW'(DEPTH)) |-> !full);
  a_ptr_diff: assert property (@(posedge clk) disable iff (reset)
    (!empty && !full) |-> (wr_ptr != rd_ptr));
  a_count_max: assert property (@(posedge clk) disable iff (reset)
    count <= CW'(DEPTH));
  a_rd_valid: assert property (@(posedge clk) disable iff (reset)
    rd_valid |-> $past(valid_read));
`else
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scoreboard bench driving a DEPTH=8 and a DEPTH=6 FIFO in lockstep
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rs, w, r, c;
  logic [7:0] d;
  logic [7:0] dout [2];
  logic rdv [2], emp [2], ful [2], ae [2], af [2], ov [2], un [2];
  logic [3:0] cnt8;
  logic [2:0] cnt6;
  int checks = 0;
  int failures = 0;
  logic [7:0] st [2][$];
  logic [7:0] ex [2][$];
  logic [7:0] mdo [2];
  logic mrv [2], mov [2], mun [2];

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(8)) dut8 (
    .clk(clk), .reset(rs), .write(w), .data_in(d), .read(r), .clear_err(c),
    .data_out(dout[0]), .rd_valid(rdv[0]), .empty(emp[0]), .full(ful[0]),
    .almost_empty(ae[0]), .almost_full(af[0]), .count(cnt8),
    .overflow(ov[0]), .underflow(un[0]));

  sync_fifo_param #(.WIDTH(8), .DEPTH(6), .AF_LEVEL(5), .AE_LEVEL(1)) dut6 (
    .clk(clk), .reset(rs), .write(w), .data_in(d), .read(r), .clear_err(c),
    .data_out(dout[1]), .rd_valid(rdv[1]), .empty(emp[1]), .full(ful[1]),
    .almost_empty(ae[1]), .almost_full(af[1]), .count(cnt6),
    .overflow(ov[1]), .underflow(un[1]));

  task automatic chk(input string tag, input int k, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, k ? 6 : 8, o, e);
    end
  endtask

  task automatic model(input int k);
    int n, dp;
    logic vr, vw;
    n  = st[k].size();
    dp = k ? 6 : 8;
    vr = r && n > 0;
    vw = w && (n < dp || r);
    if (rs) begin
      st[k].delete();
      ex[k].delete();
      mdo[k] = 8'h00;
      mrv[k] = 1'b0;
      mov[k] = 1'b0;
      mun[k] = 1'b0;
    end else begin
      mrv[k] = vr;
      if (vr) ex[k].push_back(st[k].pop_front());
      if (vw) st[k].push_back(d);
      mov[k] = (w && !vw) || (mov[k] && !c);
      mun[k] = (r && !vr) || (mun[k] && !c);
    end
  endtask

  task automatic check(input int k);
    int n, dp, afl;
    n   = st[k].size();
    dp  = k ? 6 : 8;
    afl = k ? 5 : 7;
    chk("count", k, k ? 32'(cnt6) : 32'(cnt8), 32'(n));
    chk("empty", k, 32'(emp[k]), 32'(n == 0));
    chk("full", k, 32'(ful[k]), 32'(n == dp));
    chk("almost_empty", k, 32'(ae[k]), 32'(n <= 1));
    chk("almost_full", k, 32'(af[k]), 32'(n >= afl));
    chk("overflow", k, 32'(ov[k]), 32'(mov[k]));
    chk("underflow", k, 32'(un[k]), 32'(mun[k]));
    chk("rd_valid", k, 32'(rdv[k]), 32'(mrv[k]));
    if (mrv[k] && ex[k].size() > 0) mdo[k] = ex[k].pop_front();
    chk("data_out", k, 32'(dout[k]), 32'(mdo[k]));
  endtask

  task automatic step(input logic wi, input logic [7:0] di, input logic ri, input logic ci, input logic rsi);
    w = wi; d = di; r = ri; c = ci; rs = rsi;
    @(posedge clk);
    model(0);
    model(1);
    #1;
    check(0);
    check(1);
  endtask

  initial begin
    rs = 1'b1; w = 1'b0; r = 1'b0; c = 1'b0; d = 8'h00;
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk("reset_empty", 0, 32'(emp[0]), 32'd1);
    chk("reset_dout", 0, 32'(dout[0]), 32'd0);
    for (int i = 1; i <= 8; i++) step(1, 8'(i * 17), 0, 0, 0);
    chk("full_after_8w", 0, 32'(ful[0]), 32'd1);
    chk("dut6_overflow_on_extra_w", 1, 32'(ov[1]), 32'd1);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
    chk("last_read_data", 0, 32'(dout[0]), 32'h88);
    chk("empty_after_8r", 0, 32'(emp[0]), 32'd1);
    step(0, 8'h00, 0, 1, 0);
    step(1, 8'h55, 1, 0, 0);
    chk("empty_rw_underflow", 0, 32'(un[0]), 32'd1);
    chk("empty_rw_count", 0, 32'(cnt8), 32'd1);
    step(0, 8'h00, 1, 0, 0);
    chk("read_back_55", 0, 32'(dout[0]), 32'h55);
    step(0, 8'h00, 0, 1, 0);
    chk("underflow_cleared", 0, 32'(un[0]), 32'd0);
    for (int i = 1; i <= 8; i++) step(1, 8'(8'hA0 + i), 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    step(1, 8'hAA, 1, 0, 0);
    chk("full_rw_count", 0, 32'(cnt8), 32'd8);
    chk("full_rw_oldest", 0, 32'(dout[0]), 32'hA1);
    chk("full_rw_no_overflow", 0, 32'(ov[0]), 32'd0);
    step(1, 8'hBB, 0, 0, 0);
    chk("full_w_overflow", 0, 32'(ov[0]), 32'd1);
    chk("full_w_count", 0, 32'(cnt8), 32'd8);
    step(1, 8'hBC, 0, 1, 0);
    chk("set_beats_clear", 0, 32'(ov[0]), 32'd1);
    step(0, 8'h00, 0, 1, 0);
    chk("overflow_cleared", 0, 32'(ov[0]), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
    chk("newest_is_aa", 0, 32'(dout[0]), 32'hAA);
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 20; i++)
      step((i < 14) && (i % 4 != 3), 8'(8'h30 + i), (i % 2 == 1) || (i >= 14), 0, 0);
    for (int i = 0; i < 4; i++) step(1, 8'(8'hC0 + $urandom_range(0, 15)), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'hD0, 0, 0, 0);
    chk("pre_reset_count", 0, 32'(cnt8), 32'd4);
    step(1, 8'hEE, 0, 0, 1);
    chk("reset_mid_count", 0, 32'(cnt8), 32'd0);
    chk("reset_mid_empty", 0, 32'(emp[0]), 32'd1);
    chk("reset_mid_dout", 0, 32'(dout[0]), 32'd0);
    chk("reset_mid_rd_valid", 0, 32'(rdv[0]), 32'd0);
    step(0, 8'h00, 1, 0, 0);
    chk("post_reset_underflow", 0, 32'(un[0]), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
